multi_channel_mem_controller: RTL and testbench

//  Successor to the single-port memory controller: arbitrates NUM_CONSUMERS LSU-style

---
 rtl/multi_channel_mem_controller.sv | 180 ++++++++++++++++++
 tb/tb_multi_channel_mem_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_mem_controller.sv
// Round-robin arbiter + per-channel FSMs mapping NUM_CONSUMERS LSU requesters onto NUM_CHANNELS
// memory ports. Define MEM_CTRL_PERF_EN to add saturating completed read/write counters.
module multi_channel_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS-1:0],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS-1:0],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS-1:0],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS-1:0],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS-1:0],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS-1:0],
    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS-1:0],
    output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS-1:0],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [15:0]              perf_read_count,
    output logic [15:0]              perf_write_count
`endif
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int HW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELAY} ch_state_t;

    ch_state_t                state [NUM_CHANNELS];
    logic [CW-1:0]            owner [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  op_read;
    logic [NUM_CHANNELS-1:0]  rd_done, wr_done;
    logic [NUM_CONSUMERS-1:0] claimed, response_valid, pending;
    logic [CW-1:0]            rr_ptr, winner, cand;
    logic [HW-1:0]            grant_ch;
    logic                     ch_free, win_found, do_grant;

    assign consumer_read_ready  = response_valid & consumer_read_valid;
    assign consumer_write_ready = response_valid & consumer_write_valid;
    assign pending = (consumer_read_valid | consumer_write_valid)
                   & ~(consumer_read_ready | consumer_write_ready) & ~claimed;

    // Lowest idle channel and first pending consumer at/after rr_ptr; descending
    // loops leave the lowest match as the final assignment.
    always_comb begin
        grant_ch  = '0;
        ch_free   = 1'b0;
        winner    = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int h = NUM_CHANNELS - 1; h >= 0; h--) begin
            if (state[h] == IDLE) begin
                grant_ch = HW'(h);
                ch_free  = 1'b1;
            end
        end
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            cand = CW'((int'(rr_ptr) + i) % NUM_CONSUMERS);
            if (pending[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    assign do_grant = ch_free & win_found;

    always_comb begin
        rd_done = '0;
        wr_done = '0;
        for (int h = 0; h < NUM_CHANNELS; h++) begin
            rd_done[h] = (state[h] == ISSUE) &  op_read[h] & mem_read_ready[h];
            wr_done[h] = (state[h] == ISSUE) & ~op_read[h] & mem_write_ready[h];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int h = 0; h < NUM_CHANNELS; h++) begin
                state[h]             <= IDLE;
                owner[h]             <= '0;
                mem_read_address[h]  <= '0;
                mem_write_address[h] <= '0;
                mem_write_data[h]    <= '0;
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) consumer_read_data[c] <= '0;
            op_read         <= '0;
            mem_read_valid  <= '0;
            mem_write_valid <= '0;
            response_valid  <= '0;
            claimed         <= '0;
            rr_ptr          <= '0;
        end else begin
            for (int h = 0; h < NUM_CHANNELS; h++) begin
                case (state[h])
                    IDLE: begin
                        if (do_grant && grant_ch == HW'(h)) begin
                            state[h] <= ISSUE;
                            owner[h] <= winner;
                            // A consumer asserting both gets its read first
                            if (consumer_read_valid[winner]) begin
                                op_read[h]          <= 1'b1;
                                mem_read_valid[h]   <= 1'b1;
                                mem_read_address[h] <= consumer_read_address[winner];
                            end else begin
                                op_read[h]           <= 1'b0;
                                mem_write_valid[h]   <= 1'b1;
                                mem_write_address[h] <= consumer_write_address[winner];
                                mem_write_data[h]    <= consumer_write_data[winner];
                            end
                        end
                    end
                    ISSUE: begin
                        if (rd_done[h]) begin
                            mem_read_valid[h]             <= 1'b0;
                            response_valid[owner[h]]     <= 1'b1;
                            consumer_read_data[owner[h]] <= mem_read_data[h];
                            state[h]                     <= RELAY;
                        end else if (wr_done[h]) begin
                            mem_write_valid[h]       <= 1'b0;
                            response_valid[owner[h]] <= 1'b1;
                            state[h]                 <= RELAY;
                        end
                    end
                    RELAY: begin
                        if (!(consumer_read_valid[owner[h]] || consumer_write_valid[owner[h]])) begin
                            response_valid[owner[h]] <= 1'b0;
                            claimed[owner[h]]        <= 1'b0;
                            state[h]                 <= IDLE;
                        end
                    end
                    default: state[h] <= IDLE;
                endcase
            end
            if (do_grant) begin
                claimed[winner] <= 1'b1;
                rr_ptr <= (winner == CW'(NUM_CONSUMERS - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

`ifdef MEM_CTRL_PERF_EN
    logic [15:0] rd_inc, wr_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        rd_inc = '0;
        wr_inc = '0;
        for (int h = 0; h < NUM_CHANNELS; h++) begin
            rd_inc = rd_inc + {15'd0, rd_done[h]};
            wr_inc = wr_inc + {15'd0, wr_done[h]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_read_count  <= '0;
            perf_write_count <= '0;
        end else begin
            perf_read_count  <= sat_add(perf_read_count, rd_inc);
            perf_write_count <= sat_add(perf_write_count, wr_inc);
        end
    end
`endif

endmodule

// File: tb/tb_multi_channel_mem_controller.sv
// Directed + randomized bench: memory device model on the channel side, reference
// memory contents and expected grant orders derived from round-robin rules.
module tb_multi_channel_mem_controller;
    localparam int NC  = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  rv, wv, crr, cwr;
    logic [7:0]  ra [3:0];
    logic [7:0]  wa [3:0];
    logic [15:0] wd [3:0];
    logic [15:0] crd [3:0];
    logic [1:0]  mrv, mrr, mwv, mwr;
    logic [7:0]  mra [1:0];
    logic [7:0]  mwa [1:0];
    logic [15:0] mrd [1:0];
    logic [15:0] mwd [1:0];
`ifdef MEM_CTRL_PERF_EN
    logic [15:0] perf_rd, perf_wr;
`endif

    multi_channel_mem_controller #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr),
        .mem_read_data(mrd), .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
`ifdef MEM_CTRL_PERF_EN
        , .perf_read_count(perf_rd), .perf_write_count(perf_wr)
`endif
    );

    int n_cmp = 0, n_bad = 0, n_rd = 0, n_wr = 0;
    logic [15:0] ref_mem [256];
    logic [15:0] mem_model [256];
    logic [15:0] last_rd [4];
    logic init_mem;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : {a ^ 8'hC3, a};
    endfunction

    // Memory device: combinational read, write on accepted handshake
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= init_val(8'(i));
        end else begin
            for (int h = 0; h < NCH; h++)
                if (mwv[h] && mwr[h]) mem_model[mwa[h]] <= mwd[h];
        end
    end
    always_comb for (int h = 0; h < NCH; h++) mrd[h] = mem_model[mra[h]];

    logic [1:0] rd_rdy, wr_rdy, rnd_rd, rnd_wr;
    logic rand_rdy;
    always @(negedge clk) begin
        rnd_rd = 2'($urandom);
        rnd_wr = 2'($urandom);
    end
    assign mrr = rand_rdy ? rnd_rd : rd_rdy;
    assign mwr = rand_rdy ? rnd_wr : wr_rdy;

    typedef struct { int ch; bit wr; logic [7:0] addr; logic [15:0] data; } ev_t;
    ev_t log_q[$];
    logic [1:0] prev_rv = '0, prev_wv = '0;
    always @(negedge clk) begin
        for (int h = 0; h < NCH; h++) begin
            if (mrv[h] && !prev_rv[h]) log_q.push_back('{h, 1'b0, mra[h], 16'h0});
            if (mwv[h] && !prev_wv[h]) log_q.push_back('{h, 1'b1, mwa[h], mwd[h]});
        end
        prev_rv = mrv;
        prev_wv = mwv;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input int c, input logic [7:0] a, output logic [15:0] d);
        bit got;
        got = 1'b0;
        d = '0;
        rv[c] = 1'b1;
        ra[c] = a;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (crr[c]) begin
                got = 1'b1;
                d = crd[c];
            end
        end
        chk("rd_handshake", 32'(got), 32'd1);
        if (got) n_rd++;
        rv[c] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input int c, input logic [7:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        wv[c] = 1'b1;
        wa[c] = a;
        wd[c] = d;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (cwr[c]) got = 1'b1;
        end
        chk("wr_handshake", 32'(got), 32'd1);
        if (got) n_wr++;
        wv[c] = 1'b0;
        ref_mem[a] = d;
        @(negedge clk);
    endtask

    // Each consumer owns a private 16-word region so per-consumer order defines the model
    task automatic cons_seq(input int c);
        logic [7:0]  a;
        logic [15:0] d;
        for (int k = 0; k < 3; k++) begin
            a = 8'(c * 16 + int'($urandom_range(15)));
            if ($urandom_range(1) == 1) begin
                d = 16'($urandom);
                do_write(c, a, d);
                chk("rd_data_persist", 32'(crd[c]), 32'(last_rd[c]));
            end else begin
                do_read(c, a, d);
                chk("rand_rd", 32'(d), 32'(ref_mem[a]));
                last_rd[c] = d;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d0, d1, d2, d3, d4;
        bit got, wdone;
        int nw;
        logic [7:0] ch1_addr [$];

        reset = 1'b1; init_mem = 1'b1; rand_rdy = 1'b0;
        rv = '0; wv = '0; rd_rdy = 2'b11; wr_rdy = 2'b11;
        for (int i = 0; i < NC; i++) begin ra[i] = '0; wa[i] = '0; wd[i] = '0; last_rd[i] = '0; end
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        repeat (3) @(negedge clk);
        reset = 1'b0; init_mem = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_mrv", 32'(mrv), 32'd0);
        chk("rst_mwv", 32'(mwv), 32'd0);
        chk("rst_crr", 32'(crr), 32'd0);
        chk("rst_cwr", 32'(cwr), 32'd0);
        chk("rst_mra0", 32'(mra[0]), 32'd0);
        for (int c = 0; c < NC; c++) chk("rst_crd", 32'(crd[c]), 32'd0);

        // T1: single read, minimum latency, release, channel 0 reusable
        rv[1] = 1'b1; ra[1] = 8'h10;
        @(negedge clk);
        chk("t1_mrv", 32'(mrv), 32'b01);
        chk("t1_mra", 32'(mra[0]), 32'h10);
        chk("t1_not_yet", 32'(crr), 32'd0);
        @(negedge clk);
        chk("t1_ready", 32'(crr), 32'b0010);
        chk("t1_data", 32'(crd[1]), 32'h1234);
        chk("t1_mrv_low", 32'(mrv), 32'd0);
        rv[1] = 1'b0;
        #1;
        chk("t1_ready_drop", 32'(crr), 32'd0);
        @(negedge clk);
        rv[3] = 1'b1; ra[3] = 8'h11;
        @(negedge clk);
        chk("t1_ch0_reuse", 32'(mrv), 32'b01);
        chk("t1_ch0_addr", 32'(mra[0]), 32'h11);
        @(negedge clk);
        chk("t1_c3_ready", 32'(crr[3]), 32'd1);
        chk("t1_c3_data", 32'(crd[3]), 32'(ref_mem[8'h11]));
        rv[3] = 1'b0;
        @(negedge clk);

        // T2: four simultaneous reads, round-robin order across two channels
        log_q.delete();
        fork
            do_read(0, 8'h40, d0);
            do_read(1, 8'h41, d1);
            do_read(2, 8'h42, d2);
            do_read(3, 8'h43, d3);
            begin
                @(negedge clk);
                chk("t2_first", 32'(mrv), 32'b01);
                @(negedge clk);
                chk("t2_second", 32'(mrv), 32'b10);
            end
        join
        chk("t2_d0", 32'(d0), 32'(ref_mem[8'h40]));
        chk("t2_d1", 32'(d1), 32'(ref_mem[8'h41]));
        chk("t2_d2", 32'(d2), 32'(ref_mem[8'h42]));
        chk("t2_d3", 32'(d3), 32'(ref_mem[8'h43]));
        chk("t2_nlog", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("t2_grant_ch", 32'(log_q[i].ch), 32'(i % 2));
            chk("t2_grant_addr", 32'(log_q[i].addr), 32'(8'h40 + i));
        end

        // T3: stalled read on ch0 while a write completes on ch1
        rd_rdy = 2'b00;
        log_q.delete();
        rv[3] = 1'b1; ra[3] = 8'h30;
        @(negedge clk);
        wv[2] = 1'b1; wa[2] = 8'h20; wd[2] = 16'hBEEF;
        wdone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_vld", 32'(mrv[0]), 32'd1);
            chk("t3_stall_addr", 32'(mra[0]), 32'h30);
            if (cwr[2] && !wdone) begin
                wdone = 1'b1;
                wv[2] = 1'b0;
            end
        end
        chk("t3_wr_done", 32'(wdone), 32'd1);
        ref_mem[8'h20] = 16'hBEEF;
        nw = 0;
        foreach (log_q[i]) begin
            if (log_q[i].wr) begin
                nw++;
                chk("t3_wr_ch", 32'(log_q[i].ch), 32'd1);
                chk("t3_wr_addr", 32'(log_q[i].addr), 32'h20);
                chk("t3_wr_data", 32'(log_q[i].data), 32'hBEEF);
            end
        end
        chk("t3_nwr", 32'(nw), 32'd1);
        rd_rdy = 2'b11;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (crr[3]) got = 1'b1;
        end
        chk("t3_rd_done", 32'(got), 32'd1);
        chk("t3_rd_data", 32'(crd[3]), 32'(ref_mem[8'h30]));
        rv[3] = 1'b0;
        @(negedge clk);
        do_read(2, 8'h20, d4);
        chk("t3_readback", 32'(d4), 32'hBEEF);

        // T4: ch0 held by a stalled read; c0 re-requests but c1 is served in between
        rd_rdy = 2'b10;
        log_q.delete();
        rv[3] = 1'b1; ra[3] = 8'h33;
        @(negedge clk);
        fork
            begin
                do_read(0, 8'h50, d0);
                do_read(0, 8'h50, d2);
            end
            do_read(1, 8'h51, d1);
        join
        chk("t4_ch0_held", 32'(mra[0]), 32'h33);
        chk("t4_d0a", 32'(d0), 32'(ref_mem[8'h50]));
        chk("t4_d0b", 32'(d2), 32'(ref_mem[8'h50]));
        chk("t4_d1", 32'(d1), 32'(ref_mem[8'h51]));
        foreach (log_q[i]) if (log_q[i].ch == 1) ch1_addr.push_back(log_q[i].addr);
        chk("t4_n", 32'(ch1_addr.size()), 32'd3);
        if (ch1_addr.size() == 3) begin
            chk("t4_order0", 32'(ch1_addr[0]), 32'h50);
            chk("t4_order1", 32'(ch1_addr[1]), 32'h51);
            chk("t4_order2", 32'(ch1_addr[2]), 32'h50);
        end
        rd_rdy = 2'b11;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (crr[3]) got = 1'b1;
        end
        chk("t4_c3_done", 32'(got), 32'd1);
        chk("t4_c3_data", 32'(crd[3]), 32'(ref_mem[8'h33]));
        rv[3] = 1'b0;
        @(negedge clk);

        // T7: consumer abandons its request mid-issue; no visible ready, no hang
        rd_rdy = 2'b00;
        rv[1] = 1'b1; ra[1] = 8'h70;
        @(negedge clk);
        chk("t7_issue", 32'(mrv), 32'b01);
        rv[1] = 1'b0;
        @(negedge clk);
        rd_rdy = 2'b11;
        @(negedge clk);
        chk("t7_no_ready", 32'(crr), 32'd0);
        chk("t7_mrv_low", 32'(mrv), 32'd0);
        @(negedge clk);
        chk("t7_no_ready2", 32'(crr), 32'd0);
        do_read(1, 8'h71, d0);
        chk("t7_after", 32'(d0), 32'(ref_mem[8'h71]));

        // T5: reset while a read is issuing
        rd_rdy = 2'b00;
        rv[1] = 1'b1; ra[1] = 8'h10;
        @(negedge clk);
        chk("t5_issue", 32'(|mrv), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_mrv", 32'(mrv), 32'd0);
        chk("t5_mwv", 32'(mwv), 32'd0);
        chk("t5_crr", 32'(crr), 32'd0);
        chk("t5_cwr", 32'(cwr), 32'd0);
        chk("t5_crd1", 32'(crd[1]), 32'd0);
        rv[1] = 1'b0; reset = 1'b0; rd_rdy = 2'b11;
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < NC; i++) last_rd[i] = '0;
        @(negedge clk);
        do_read(2, 8'h60, d0);
        chk("t5_after", 32'(d0), 32'(ref_mem[8'h60]));
        last_rd[2] = d0;

        // Random traffic with random memory backpressure
        rand_rdy = 1'b1;
        repeat (5) begin
            fork
                cons_seq(0);
                cons_seq(1);
                cons_seq(2);
                cons_seq(3);
            join
        end
        rand_rdy = 1'b0;
        @(negedge clk);

`ifdef MEM_CTRL_PERF_EN
        chk("perf_rd", 32'(perf_rd), 32'(n_rd));
        chk("perf_wr", 32'(perf_wr), 32'(n_wr));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
